// File: rtl/seq_alu.sv
// Registered DataWidth-bit ALU with a V/N/C/Z flag register and a multi-cycle
// shift-add multiplier behind a Start/Done handshake.
module seq_alu #(
  parameter int DataWidth = 8,
  parameter int FlagBits  = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [3:0]           FuncOp,
  input  logic [DataWidth-1:0] A,
  input  logic [DataWidth-1:0] B,
  output logic                 Ready,
  output logic                 Done,
  output logic                 Err,
  output logic [DataWidth-1:0] Y,
  output logic [DataWidth-1:0] YHi,
  output logic [FlagBits-1:0]  Flags
);

  localparam int CntW = $clog2(DataWidth + 1);
  localparam int Msb  = DataWidth - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MULT = 1'b1} state_t;

  state_t               state_r, state_nxt_s;
  logic [CntW-1:0]      cnt_r;
  logic [DataWidth-1:0] mcand_r, acc_hi_r, acc_lo_r;
  logic [DataWidth-1:0] y_r, yhi_r;
  logic [FlagBits-1:0]  flags_r;
  logic                 done_r, err_r;

  logic                 cin_s, add_cin_s, sub_cin_s;
  logic [DataWidth:0]   add_sum_s, sub_sum_s;
  logic [DataWidth-1:0] res_s;
  logic                 c_s, v_s, legal_s, wr_y_s;
  logic [FlagBits-1:0]  alu_flags_s;

  logic [DataWidth:0]   step_sum_s;
  logic [DataWidth-1:0] nxt_hi_s, nxt_lo_s;
  logic                 last_s;
  logic [FlagBits-1:0]  mul_flags_s;

  // Single-cycle datapath: carry-in always comes from the registered C flag.
  always_comb begin
    cin_s     = flags_r[1];
    add_cin_s = (FuncOp == OP_ADC) ? cin_s : 1'b0;
    sub_cin_s = (FuncOp == OP_SBC) ? cin_s : 1'b1;
    add_sum_s = {1'b0, A} + {1'b0, B} + {{DataWidth{1'b0}}, add_cin_s};
    sub_sum_s = {1'b0, A} + {1'b0, ~B} + {{DataWidth{1'b0}}, sub_cin_s};
    res_s     = '0;
    c_s       = 1'b0;
    v_s       = 1'b0;
    legal_s   = 1'b1;
    wr_y_s    = 1'b1;
    case (FuncOp)
      OP_ADD, OP_ADC: begin
        res_s = add_sum_s[Msb:0];
        c_s   = add_sum_s[DataWidth];
        v_s   = (A[Msb] == B[Msb]) && (add_sum_s[Msb] != A[Msb]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        res_s  = sub_sum_s[Msb:0];
        c_s    = sub_sum_s[DataWidth];
        v_s    = (A[Msb] != B[Msb]) && (sub_sum_s[Msb] != A[Msb]);
        wr_y_s = (FuncOp != OP_CMP);
      end
      OP_AND: res_s = A & B;
      OP_OR:  res_s = A | B;
      OP_XOR: res_s = A ^ B;
      OP_SHL: begin
        res_s = {A[Msb-1:0], 1'b0};
        c_s   = A[Msb];
      end
      OP_SHR: begin
        res_s = {1'b0, A[Msb:1]};
        c_s   = A[0];
      end
      OP_ROL: begin
        res_s = {A[Msb-1:0], cin_s};
        c_s   = A[Msb];
      end
      OP_ROR: begin
        res_s = {cin_s, A[Msb:1]};
        c_s   = A[0];
      end
      OP_MUL: legal_s = 1'b1;
      default: begin
        legal_s = 1'b0;
        wr_y_s  = 1'b0;
      end
    endcase
    alu_flags_s = {v_s, res_s[Msb], c_s, ~|res_s};
  end

  // One shift-add step: {carry, hi + mcand?, lo} shifted right by one.
  always_comb begin
    step_sum_s  = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, mcand_r} : {(DataWidth+1){1'b0}});
    nxt_hi_s    = step_sum_s[DataWidth:1];
    nxt_lo_s    = {step_sum_s[0], acc_lo_r[Msb:1]};
    last_s      = (cnt_r == CntW'(1));
    mul_flags_s = {1'b0, nxt_hi_s[Msb], |nxt_hi_s, ~|{nxt_hi_s, nxt_lo_s}};
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Start && (FuncOp == OP_MUL)) state_nxt_s = ST_MULT;
        else                              state_nxt_s = ST_IDLE;
      end
      ST_MULT: begin
        if (last_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_MULT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    Ready = 1'b0;
    case (state_r)
      ST_IDLE: Ready = 1'b1;
      ST_MULT: Ready = 1'b0;
      default: Ready = 1'b0;
    endcase
  end

  // Result, flag and multiplier registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_r    <= '0;
      mcand_r  <= '0;
      acc_hi_r <= '0;
      acc_lo_r <= '0;
      y_r      <= '0;
      yhi_r    <= '0;
      flags_r  <= 4'b0000;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            if (FuncOp == OP_MUL) begin
              mcand_r  <= A;
              acc_hi_r <= '0;
              acc_lo_r <= B;
              cnt_r    <= CntW'(DataWidth);
            end else if (legal_s) begin
              if (wr_y_s) begin
                y_r   <= res_s;
                yhi_r <= '0;
              end
              flags_r <= alu_flags_s;
              done_r  <= 1'b1;
            end else begin
              done_r <= 1'b1;
              err_r  <= 1'b1;
            end
          end
        end
        ST_MULT: begin
          acc_hi_r <= nxt_hi_s;
          acc_lo_r <= nxt_lo_s;
          cnt_r    <= cnt_r - CntW'(1);
          if (last_s) begin
            y_r     <= nxt_lo_s;
            yhi_r   <= nxt_hi_s;
            flags_r <= mul_flags_s;
            done_r  <= 1'b1;
          end
        end
        default: done_r <= 1'b0;
      endcase
    end
  end

  assign Y     = y_r;
  assign YHi   = yhi_r;
  assign Flags = flags_r;
  assign Done  = done_r;
  assign Err   = err_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: chained single-cycle vector table plus
// hand-written MUL and reset sequences.
module tb_seq_alu;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [3:0] FuncOp;
  logic [7:0] A, B;
  logic       Ready, Done, Err;
  logic [7:0] Y, YHi;
  logic [3:0] Flags;

  int tests  = 0;
  int failed = 0;

  seq_alu #(.DataWidth(8), .FlagBits(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .FuncOp(FuncOp),
    .A(A), .B(B), .Ready(Ready), .Done(Done), .Err(Err),
    .Y(Y), .YHi(YHi), .Flags(Flags)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic [7:0] yhi;
    logic [3:0] flags;
    logic       err;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] y, input logic [7:0] yhi,
                              input logic [3:0] flags, input logic err);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.y = y; v.yhi = yhi; v.flags = flags; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    FuncOp = op; A = a; B = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [7:0] y, input logic [7:0] yhi,
                              input logic [3:0] flags, input logic err);
    check({name, "_done"}, 32'(Done), 32'd1);
    check({name, "_err"}, 32'(Err), 32'(err));
    check({name, "_y"}, 32'(Y), 32'(y));
    check({name, "_yhi"}, 32'(YHi), 32'(yhi));
    check({name, "_flags"}, 32'(Flags), 32'(flags));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_ready"}, 32'(Ready), 32'd1);
    check({name, "_done"}, 32'(Done), 32'd0);
    check({name, "_err"}, 32'(Err), 32'd0);
    check({name, "_y"}, 32'(Y), 32'h00);
    check({name, "_yhi"}, 32'(YHi), 32'h00);
    check({name, "_flags"}, 32'(Flags), 32'h0);
  endtask

  initial begin
    int done_cnt;
    int done_at;
    logic [7:0] cap_y, cap_yhi;
    logic [3:0] cap_flags;
    logic       cap_err;

    // Chained vectors; flags carry from row to row.
    vecs[0]  = mk(4'd0,  8'h7F, 8'h01, 8'h80, 8'h00, 4'b1100, 1'b0); // ADD overflow
    vecs[1]  = mk(4'd1,  8'hFF, 8'h00, 8'hFF, 8'h00, 4'b0100, 1'b0); // ADC C=0
    vecs[2]  = mk(4'd2,  8'h10, 8'h10, 8'h00, 8'h00, 4'b0011, 1'b0); // SUB equal
    vecs[3]  = mk(4'd3,  8'h00, 8'h01, 8'hFF, 8'h00, 4'b0100, 1'b0); // SBC C=1
    vecs[4]  = mk(4'd7,  8'h80, 8'h00, 8'h00, 8'h00, 4'b0011, 1'b0); // SHL
    vecs[5]  = mk(4'd9,  8'h80, 8'h00, 8'h01, 8'h00, 4'b0010, 1'b0); // ROL C=1
    vecs[6]  = mk(4'd4,  8'h0F, 8'hF0, 8'h00, 8'h00, 4'b0001, 1'b0); // AND clears C
    vecs[7]  = mk(4'd10, 8'h01, 8'h00, 8'h00, 8'h00, 4'b0011, 1'b0); // ROR C=0
    vecs[8]  = mk(4'd11, 8'h05, 8'h06, 8'h00, 8'h00, 4'b0100, 1'b0); // CMP keeps Y
    vecs[9]  = mk(4'd5,  8'h30, 8'h05, 8'h35, 8'h00, 4'b0000, 1'b0); // OR
    vecs[10] = mk(4'd6,  8'hAA, 8'hAA, 8'h00, 8'h00, 4'b0001, 1'b0); // XOR
    vecs[11] = mk(4'd8,  8'h81, 8'h00, 8'h40, 8'h00, 4'b0010, 1'b0); // SHR
    vecs[12] = mk(4'd0,  8'hFF, 8'h01, 8'h00, 8'h00, 4'b0011, 1'b0); // ADD wrap
    vecs[13] = mk(4'd1,  8'h00, 8'h00, 8'h01, 8'h00, 4'b0000, 1'b0); // ADC C=1
    vecs[14] = mk(4'd2,  8'h80, 8'h01, 8'h7F, 8'h00, 4'b1010, 1'b0); // SUB overflow
    vecs[15] = mk(4'hF,  8'h12, 8'h34, 8'h7F, 8'h00, 4'b1010, 1'b1); // illegal
    vecs[16] = mk(4'hD,  8'h56, 8'h78, 8'h7F, 8'h00, 4'b1010, 1'b1); // illegal

    Reset = 1'b1; Start = 1'b0; FuncOp = 4'd0; A = 8'h00; B = 8'h00;
    #12;
    check_reset_vals("por");
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Back-to-back: Start stays high across the whole table.
    for (int i = 0; i < 17; i++) begin
      apply_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check_result($sformatf("vec%0d", i), vecs[i].y, vecs[i].yhi, vecs[i].flags, vecs[i].err);
      check($sformatf("vec%0d_ready", i), 32'(Ready), 32'd1);
    end

    @(posedge Clk); #1;
    check("idle_done_low", 32'(Done), 32'd0);

    // MUL 0xFF x 0xFF with Start and operands toggled while busy.
    apply_op(4'd12, 8'hFF, 8'hFF);
    check("mul_busy_k", 32'(Ready), 32'd0);
    done_cnt = 0; done_at = 0;
    cap_y = 8'h00; cap_yhi = 8'h00; cap_flags = 4'h0; cap_err = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      Start  = (i <= 7) ? i[0] : 1'b0;
      FuncOp = (i <= 7) ? 4'd0 : 4'd12;
      A      = 8'(i * 37);
      B      = 8'(i * 11);
      @(posedge Clk); #1;
      if (Done) begin
        done_cnt++;
        done_at = i;
        cap_y = Y; cap_yhi = YHi; cap_flags = Flags; cap_err = Err;
        check("mul_ready_in_done", 32'(Ready), 32'd1);
      end else if (i < 8) begin
        check($sformatf("mul_busy_%0d", i), 32'(Ready), 32'd0);
      end
    end
    Start = 1'b0;
    check("mul_done_count", 32'(done_cnt), 32'd1);
    check("mul_latency", 32'(done_at), 32'd8);
    check("mul_y", 32'(cap_y), 32'h01);
    check("mul_yhi", 32'(cap_yhi), 32'hFE);
    check("mul_flags", 32'(cap_flags), 32'h6);
    check("mul_err", 32'(cap_err), 32'd0);
    check("mul_idle_ready", 32'(Ready), 32'd1);

    // CMP after MUL keeps Y and YHi; a normal op then clears YHi.
    apply_op(4'd11, 8'h03, 8'h03);
    check_result("cmp_after_mul", 8'h01, 8'hFE, 4'b0011, 1'b0);
    apply_op(4'd0, 8'h01, 8'h02);
    check_result("add_clr_yhi", 8'h03, 8'h00, 4'b0000, 1'b0);

    // Reset asserted mid-cycle takes effect without a clock edge.
    #3; Reset = 1'b1; #1;
    check_reset_vals("mid_reset");
    Reset = 1'b0;
    @(posedge Clk); #1;

    apply_op(4'd0, 8'h05, 8'h06);
    check_result("add_post_reset", 8'h0B, 8'h00, 4'b0000, 1'b0);

    // Reset three cycles into a MUL aborts it.
    apply_op(4'd12, 8'h0F, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
    end
    check("mul_abort_busy", 32'(Ready), 32'd0);
    #2; Reset = 1'b1; #1;
    check_reset_vals("mul_abort");
    Reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      if (Done) done_cnt++;
    end
    check("mul_abort_no_done", 32'(done_cnt), 32'd0);
    check("mul_abort_ready", 32'(Ready), 32'd1);
    check("mul_abort_y", 32'(Y), 32'h00);

    // Fresh MUL after the abort: 0x0D x 0x0B = 0x008F.
    apply_op(4'd12, 8'h0D, 8'h0B);
    done_at = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done_at == 0) begin
        @(posedge Clk); #1;
        if (Done) done_at = i;
      end
    end
    check("mul2_latency", 32'(done_at), 32'd8);
    check("mul2_y", 32'(Y), 32'h8F);
    check("mul2_yhi", 32'(YHi), 32'h00);
    check("mul2_flags", 32'(Flags), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
